signal_monitor: RTL and testbench

- Multi-channel successor to the single-pin debug passthrough used in the signal_debug tree.
- Each channel synchronises an asynchronous board input, detects edges, stretches activity onto a per-channel LED for visibility, and counts edges.
- One channel, chosen at run time, is mirrored to a probe pin, and its edge count is exposed for a logic analyser or readout.

---
 rtl/sigmon_pkg.sv | 16 +
 rtl/sigmon_chan.sv | 68 ++++++
 rtl/signal_monitor.sv | 74 +++++++
 tb/tb_signal_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sigmon_pkg.sv
// Shared defaults and helpers for the signal_monitor slice.
package sigmon_pkg;

    localparam int CH          = 4;
    localparam int CNT_W       = 16;
    localparam int STRETCH_CYC = 5000000;
    localparam int SYNC_STAGES = 2;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sigmon_chan.sv
// One monitored channel: synchroniser, edge detect, LED stretch and edge counter.
// SIGMON_CNT_WRAP_EN selects a wrapping edge counter instead of a saturating one.
module sigmon_chan #(
    parameter int CNT_W       = sigmon_pkg::CNT_W,
    parameter int STRETCH_CYC = sigmon_pkg::STRETCH_CYC,
    parameter int SYNC_STAGES = sigmon_pkg::SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_pin,
    output logic             s,
    output logic             e,
    output logic             led,
    output logic [CNT_W-1:0] cnt
);
    import sigmon_pkg::*;

    localparam int STR_W = clog2_min1(STRETCH_CYC + 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYC);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic [STR_W-1:0]       str_cnt;
    logic [STR_W-1:0]       str_next;

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
`ifdef SIGMON_CNT_WRAP_EN
        return c + CNT_W'(1);
`else
        return (&c) ? c : c + CNT_W'(1);
`endif
    endfunction

    assign s = sync_p0[SYNC_STAGES-1];

    always_comb begin
        str_next = str_cnt;
        if (e)
            str_next = STR_LOAD;
        else if (str_cnt != '0)
            str_next = str_cnt - STR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
            e       <= 1'b0;
            str_cnt <= '0;
            led     <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_pin};
            // p1: previous sample; edge pulse registered so counters see it one cycle later
            prev_p1 <= s;
            e       <= s ^ prev_p1;
            // p2: stretch and count consume the registered edge pulse
            str_cnt <= str_next;
            led     <= (str_next != '0);
            if (clr)
                cnt <= '0;
            else if (e)
                cnt <= cnt_step(cnt);
        end
    end

endmodule

// File: rtl/signal_monitor.sv
// Multi-channel signal monitor top: per-channel monitors plus selected-channel mirror.
// Build option SIGMON_CNT_WRAP_EN (in sigmon_chan) makes edge counters wrap.
module signal_monitor #(
    parameter int CH          = sigmon_pkg::CH,
    parameter int CNT_W       = sigmon_pkg::CNT_W,
    parameter int STRETCH_CYC = sigmon_pkg::STRETCH_CYC,
    parameter int SYNC_STAGES = sigmon_pkg::SYNC_STAGES,
    localparam int SEL_W      = sigmon_pkg::clog2_min1(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    in_pins,
    input  logic [SEL_W-1:0] sel,
    input  logic             clr,
    output logic             out_pin,
    output logic [CH-1:0]    out_leds,
    output logic             high_led,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             activity
);
    import sigmon_pkg::*;

    logic [CH-1:0]    s;
    logic [CH-1:0]    e;
    logic [CH-1:0]    led;
    logic [CNT_W-1:0] cnt [CH];
    logic             s_sel;
    logic [CNT_W-1:0] cnt_sel;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        sigmon_chan #(
            .CNT_W      (CNT_W),
            .STRETCH_CYC(STRETCH_CYC),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .in_pin(in_pins[i]),
            .s     (s[i]),
            .e     (e[i]),
            .led   (led[i]),
            .cnt   (cnt[i])
        );
    end

    // Out-of-range selections fall through to zero.
    always_comb begin
        s_sel   = 1'b0;
        cnt_sel = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SEL_W'(i)) begin
                s_sel   = s[i];
                cnt_sel = cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pin  <= 1'b0;
            edge_cnt <= '0;
            activity <= 1'b0;
        end else begin
            out_pin  <= s_sel;
            edge_cnt <= cnt_sel;
            activity <= |e;
        end
    end

    assign out_leds = led;
    assign high_led = 1'b1;

endmodule

// File: tb/tb_signal_monitor.sv
// Directed scoreboard bench for signal_monitor (CH=4, CNT_W=4, STRETCH_CYC=8, SYNC_STAGES=2).
module tb_signal_monitor;

    localparam int SAT_EXP =
`ifdef SIGMON_CNT_WRAP_EN
        4;
`else
        15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_pins = 4'b0000;
    logic [1:0] sel = 2'd0;
    logic       clr = 1'b0;
    logic       out_pin, high_led, activity;
    logic [3:0] out_leds, edge_cnt;

    logic [1:0] sel_b = 2'd3;
    logic       clr_b = 1'b0;
    logic       out_pin_b, high_led_b, activity_b;
    logic [2:0] out_leds_b;
    logic [3:0] edge_cnt_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          at;
        int          field;
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    signal_monitor #(.CH(4), .CNT_W(4), .STRETCH_CYC(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_pins(in_pins), .sel(sel), .clr(clr),
        .out_pin(out_pin), .out_leds(out_leds), .high_led(high_led),
        .edge_cnt(edge_cnt), .activity(activity)
    );

    // Three-channel instance so a select value past the last channel is representable.
    signal_monitor #(.CH(3), .CNT_W(4), .STRETCH_CYC(8), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .in_pins(in_pins[2:0]), .sel(sel_b), .clr(clr_b),
        .out_pin(out_pin_b), .out_leds(out_leds_b), .high_led(high_led_b),
        .edge_cnt(edge_cnt_b), .activity(activity_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] field_val(input int f);
        case (f)
            0: return 32'(out_pin);
            1: return 32'(out_leds);
            2: return 32'(high_led);
            3: return 32'(edge_cnt);
            4: return 32'(activity);
            5: return 32'(out_pin_b);
            default: return 32'(edge_cnt_b);
        endcase
    endfunction

    task automatic expect_at(input int at, input int field, input logic [31:0] val, input string name);
        exp_t x;
        x.at = at; x.field = field; x.val = val; x.name = name;
        sb.push_back(x);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                logic [31:0] act;
                act = field_val(sb[i].field);
                checks++;
                if (sb[i].at < cyc) begin
                    failures++;
                    $display("FAIL %s: check at cycle %0d missed (now %0d)", sb[i].name, sb[i].at, cyc);
                end else if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s @%0d: actual=%0d required=%0d", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int c;
        // Reset held for three edges with all inputs low.
        expect_at(1, 2, 1, "high_led_rst1");
        expect_at(2, 2, 1, "high_led_rst2");
        expect_at(3, 0, 0, "rst_out_pin");
        expect_at(3, 1, 0, "rst_out_leds");
        expect_at(3, 3, 0, "rst_edge_cnt");
        expect_at(3, 4, 0, "rst_activity");
        expect_at(3, 2, 1, "rst_high_led");
        tick(3);

        // Latency: ch0 rises right after reset release.
        c = cyc;
        rst = 1'b0;
        in_pins[0] = 1'b1;
        expect_at(c + 2, 0, 0, "lat_out_pin_early");
        expect_at(c + 3, 0, 1, "lat_out_pin");
        expect_at(c + 3, 1, 0, "lat_leds_early");
        expect_at(c + 3, 4, 0, "lat_act_early");
        expect_at(c + 4, 1, 4'b0001, "lat_leds");
        expect_at(c + 4, 4, 1, "lat_activity");
        expect_at(c + 4, 3, 0, "lat_cnt_early");
        expect_at(c + 5, 3, 1, "lat_edge_cnt");
        expect_at(c + 5, 4, 0, "lat_act_pulse");
        tick(16);

        // Stretch: single rising edge on ch1 lights its LED for 8 cycles.
        c = cyc;
        in_pins[1] = 1'b1;
        expect_at(c + 3, 1, 4'b0000, "str_before");
        expect_at(c + 4, 1, 4'b0010, "str_first");
        expect_at(c + 11, 1, 4'b0010, "str_last");
        expect_at(c + 12, 1, 4'b0000, "str_off");
        tick(14);

        // Retrigger: second edge 5 cycles into the stretch.
        c = cyc;
        in_pins[1] = 1'b0;
        expect_at(c + 12, 1, 4'b0010, "retrig_held");
        expect_at(c + 16, 1, 4'b0010, "retrig_last");
        expect_at(c + 17, 1, 4'b0000, "retrig_off");
        tick(5);
        in_pins[1] = 1'b1;
        tick(14);

        // Saturation: 20 edges on ch2.
        c = cyc;
        sel = 2'd2;
        expect_at(c + 4, 4, 1, "sat_activity");
        expect_at(c + 19, 3, 15, "sat_cnt15");
        expect_at(c + 30, 3, SAT_EXP, "sat_final");
        expect_at(c + 35, 3, SAT_EXP, "sat_hold");
        for (int k = 0; k < 20; k++) begin
            in_pins[2] = ~in_pins[2];
            tick();
        end
        tick(16);

        // Clear colliding with a ch3 edge reaching its counter.
        c = cyc;
        sel = 2'd3;
        in_pins[3] = 1'b1;
        expect_at(c + 6, 3, 0, "clr_collide");
        expect_at(c + 14, 3, 1, "clr_next_edge");
        tick(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(4);
        in_pins[3] = 1'b0;
        tick(8);

        // Select switch 0->3 and out-of-range select on the 3-channel instance.
        c = cyc;
        sel = 2'd0;
        in_pins[3] = 1'b1;
        expect_at(c + 8, 0, 1, "sel0_out_pin");
        expect_at(c + 8, 3, 0, "sel0_edge_cnt");
        expect_at(c + 8, 5, 0, "selhi_out_pin");
        expect_at(c + 8, 6, 0, "selhi_edge_cnt");
        expect_at(c + 9, 0, 1, "sel3_out_pin");
        expect_at(c + 9, 3, 2, "sel3_edge_cnt");
        expect_at(c + 9, 5, 1, "selb0_out_pin");
        expect_at(c + 9, 6, 1, "selb0_edge_cnt");
        tick(8);
        sel = 2'd3;
        sel_b = 2'd0;
        tick(2);

        // Reset mid-operation with a lit LED and nonzero count.
        c = cyc;
        in_pins[1] = 1'b0;
        expect_at(c + 4, 4, 1, "mid_activity");
        expect_at(c + 5, 1, 4'b0010, "mid_leds_lit");
        expect_at(c + 5, 3, 2, "mid_cnt");
        expect_at(c + 6, 0, 0, "mid_rst_out_pin");
        expect_at(c + 6, 1, 0, "mid_rst_leds");
        expect_at(c + 6, 3, 0, "mid_rst_cnt");
        expect_at(c + 6, 4, 0, "mid_rst_activity");
        expect_at(c + 6, 2, 1, "mid_rst_high_led");
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);

        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].at);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
